// File: rtl/alu_pkg.sv
// alu_pkg: opcodes and FSM state encoding shared by the multicycle ALU.
package alu_pkg;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_SLTU = 3'b011;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_SUB  = 3'b101;
    localparam logic [2:0] OP_SLT  = 3'b110;
    localparam logic [2:0] OP_MUL  = 3'b111;

    typedef enum logic {
        ST_IDLE,
        ST_MUL_BUSY
    } state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: shift-add multiplier, one multiplier bit per cycle, LSB first.
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             run,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] partial;

    // the last bit is folded in combinationally so the product is ready on the done cycle
    assign partial = mplier[0] ? mcand : '0;
    assign product = acc + partial;
    assign done    = run && (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (start) begin
            cnt    <= '0;
            acc    <= '0;
            mcand  <= a;
            mplier <= b;
        end else if (run && !done) begin
            cnt    <= cnt + 1'b1;
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end

endmodule

// File: rtl/alu_multicycle.sv
// alu_multicycle: registered ALU with valid/ready handshake and sequential multiply.
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             zero,
    output logic             neg,
    output logic             ovf,
    output logic             less,
    output logic             busy
);

    localparam int M = WIDTH - 1;

    state_t           state;
    state_t           state_nx;
    logic             can_load;
    logic             accept;
    logic             is_mul;
    logic             mul_done;
    logic             ld_alu;
    logic             ld_mul;
    logic             ld;
    logic [WIDTH-1:0] mul_prod;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] res_nx;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic             add_ovf;
    logic             sub_ovf;
    logic             slt;
    logic             ltu;
    logic             is_cmp;
    logic             alu_cout;
    logic             alu_ovf;
    logic             alu_less;

    assign busy     = (state == ST_MUL_BUSY);
    assign can_load = !out_valid || out_ready;
    assign in_ready = (state == ST_IDLE) && can_load;
    assign accept   = in_valid && in_ready;
    assign is_mul   = (op == OP_MUL);
    assign ld_alu   = accept && !is_mul;
    assign ld_mul   = busy && mul_done && can_load;
    assign ld       = ld_alu || ld_mul;

    assign sum     = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    assign diff    = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    assign add_ovf = (a[M] == b[M]) && (sum[M] != a[M]);
    assign sub_ovf = (a[M] != b[M]) && (diff[M] != a[M]);
    assign slt     = diff[M] ^ sub_ovf;
    assign ltu     = ~diff[WIDTH];
    assign is_cmp  = (op == OP_SUB) || (op == OP_SLT) || (op == OP_SLTU);

    always_comb begin
        alu_res  = op == OP_AND  ? a & b :
                   op == OP_OR   ? a | b :
                   op == OP_XOR  ? a ^ b :
                   op == OP_ADD  ? sum[M:0] :
                   op == OP_SUB  ? diff[M:0] :
                   op == OP_SLT  ? {{M{1'b0}}, slt} :
                   op == OP_SLTU ? {{M{1'b0}}, ltu} : '0;
        alu_cout = op == OP_ADD ? sum[WIDTH] : is_cmp ? diff[WIDTH] : 1'b0;
        alu_ovf  = op == OP_ADD ? add_ovf : op == OP_SUB ? sub_ovf : 1'b0;
        alu_less = (op == OP_SUB || op == OP_SLT) ? slt : op == OP_SLTU ? ltu : 1'b0;
        res_nx   = ld_mul ? mul_prod : alu_res;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        state_nx = (state == ST_IDLE && accept && is_mul) ? ST_MUL_BUSY :
                   (state == ST_MUL_BUSY && ld_mul)       ? ST_IDLE : state_nx;
    end

    // a load on the same edge as a drain keeps out_valid high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            cout      <= 1'b0;
            zero      <= 1'b0;
            neg       <= 1'b0;
            ovf       <= 1'b0;
            less      <= 1'b0;
        end else begin
            out_valid <= ld || (out_valid && !out_ready);
            if (ld) begin
                result <= res_nx;
                zero   <= (res_nx == '0);
                neg    <= res_nx[M];
                cout   <= ld_mul ? 1'b0 : alu_cout;
                ovf    <= ld_mul ? 1'b0 : alu_ovf;
                less   <= ld_mul ? 1'b0 : alu_less;
            end
        end
    end

    alu_mul_seq #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) u_mul (
        .clk    (clk),
        .rst    (rst),
        .start  (accept && is_mul),
        .run    (busy),
        .a      (a),
        .b      (b),
        .done   (mul_done),
        .product(mul_prod)
    );

endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle: directed self-checking bench for alu_multicycle at WIDTH=16.
module tb_alu_multicycle;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [2:0]  op;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        cout;
    logic        zero;
    logic        neg;
    logic        ovf;
    logic        less;
    logic        busy;

    int total = 0;
    int bad = 0;

    alu_multicycle #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .cout(cout), .zero(zero), .neg(neg), .ovf(ovf), .less(less), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y, input logic c);
        in_valid = 1'b1; op = o; a = x; b = y; cin = c;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0; a = 16'($urandom); b = 16'($urandom);
    endtask

    task automatic test_reset;
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        total++; if (result !== 16'h0000) begin bad++; $display("FAIL rst_result got=%h exp=0000", result); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
        total++; if ({zero, neg, cout, ovf, less} !== 5'b0) begin bad++; $display("FAIL rst_flags got=%b exp=00000", {zero, neg, cout, ovf, less}); end
        rst = 1'b0;
        @(negedge clk);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_logic;
        drive(OP_AND, 16'hAAAA, 16'h5555, 1'b0);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL and_valid got=%b exp=1", out_valid); end
        total++; if (result !== 16'h0000) begin bad++; $display("FAIL and_result got=%h exp=0000", result); end
        total++; if (zero !== 1'b1) begin bad++; $display("FAIL and_zero got=%b exp=1", zero); end
        drive(OP_XOR, 16'hAAAA, 16'h5555, 1'b0);
        total++; if (result !== 16'hFFFF) begin bad++; $display("FAIL xor_result got=%h exp=FFFF", result); end
        total++; if ({zero, neg} !== 2'b01) begin bad++; $display("FAIL xor_zn got=%b exp=01", {zero, neg}); end
        drive(OP_OR, 16'h1200, 16'h0034, 1'b1);
        total++; if (result !== 16'h1234) begin bad++; $display("FAIL or_result got=%h exp=1234", result); end
        total++; if ({cout, ovf, less} !== 3'b000) begin bad++; $display("FAIL or_flags got=%b exp=000", {cout, ovf, less}); end
    endtask

    task automatic test_add;
        drive(OP_ADD, 16'h0001, 16'h0002, 1'b0);
        total++; if (result !== 16'h0003) begin bad++; $display("FAIL add1_result got=%h exp=0003", result); end
        total++; if ({cout, ovf} !== 2'b00) begin bad++; $display("FAIL add1_cv got=%b exp=00", {cout, ovf}); end
        drive(OP_ADD, 16'hFFFF, 16'h0001, 1'b0);
        total++; if (result !== 16'h0000) begin bad++; $display("FAIL add2_result got=%h exp=0000", result); end
        total++; if ({cout, zero, ovf} !== 3'b110) begin bad++; $display("FAIL add2_czv got=%b exp=110", {cout, zero, ovf}); end
        drive(OP_ADD, 16'h7FFF, 16'h0000, 1'b1);
        total++; if (result !== 16'h8000) begin bad++; $display("FAIL add3_result got=%h exp=8000", result); end
        total++; if ({ovf, neg, cout, less} !== 4'b1100) begin bad++; $display("FAIL add3_flags got=%b exp=1100", {ovf, neg, cout, less}); end
    endtask

    task automatic test_sub;
        drive(OP_SUB, 16'h8000, 16'h0001, 1'b0);
        total++; if (result !== 16'h7FFF) begin bad++; $display("FAIL sub1_result got=%h exp=7FFF", result); end
        total++; if ({ovf, less, cout, neg} !== 4'b1110) begin bad++; $display("FAIL sub1_flags got=%b exp=1110", {ovf, less, cout, neg}); end
        drive(OP_SUB, 16'h7FFF, 16'hFFFE, 1'b0);
        total++; if (result !== 16'h8001) begin bad++; $display("FAIL sub2_result got=%h exp=8001", result); end
        total++; if ({ovf, neg, less, cout} !== 4'b1100) begin bad++; $display("FAIL sub2_flags got=%b exp=1100", {ovf, neg, less, cout}); end
        drive(OP_SLTU, 16'h0001, 16'hFFFF, 1'b0);
        total++; if (result !== 16'h0001) begin bad++; $display("FAIL sltu_result got=%h exp=0001", result); end
        total++; if ({less, cout, ovf} !== 3'b100) begin bad++; $display("FAIL sltu_flags got=%b exp=100", {less, cout, ovf}); end
        drive(OP_SLT, 16'h8000, 16'h0001, 1'b0);
        total++; if (result !== 16'h0001) begin bad++; $display("FAIL slt_result got=%h exp=0001", result); end
        drive(OP_SLT, 16'h0001, 16'h8000, 1'b0);
        total++; if ({result, less} !== {16'h0000, 1'b0}) begin bad++; $display("FAIL slt2 got=%h/%b exp=0000/0", result, less); end
    endtask

    task automatic test_mul;
        logic stall_bad;
        logic seen;
        in_valid = 1'b1; op = OP_MUL; a = 16'h0003; b = 16'h0005;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0; a = 16'($urandom); b = 16'($urandom);
        total++; if ({busy, in_ready, out_valid} !== 3'b100) begin bad++; $display("FAIL mul_start got=%b exp=100", {busy, in_ready, out_valid}); end
        stall_bad = 1'b0;
        for (int k = 1; k < 16; k++) begin
            @(posedge clk); @(negedge clk);
            if (out_valid !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b0) stall_bad = 1'b1;
        end
        total++; if (stall_bad !== 1'b0) begin bad++; $display("FAIL mul_busy_window got=%b exp=0", stall_bad); end
        @(posedge clk); @(negedge clk);
        total++; if ({out_valid, busy} !== 2'b10) begin bad++; $display("FAIL mul_done_timing got=%b exp=10", {out_valid, busy}); end
        total++; if (result !== 16'h000F) begin bad++; $display("FAIL mul1_result got=%h exp=000F", result); end
        in_valid = 1'b1; op = OP_MUL; a = 16'hFFFF; b = 16'hFFFF;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0; a = 16'h0000; b = 16'h0000;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(posedge clk); @(negedge clk);
            seen = out_valid;
        end
        total++; if (seen !== 1'b1) begin bad++; $display("FAIL mul2_timeout got=%b exp=1", seen); end
        total++; if (result !== 16'h0001) begin bad++; $display("FAIL mul2_result got=%h exp=0001", result); end
        total++; if ({zero, neg, cout, ovf, less} !== 5'b0) begin bad++; $display("FAIL mul2_flags got=%b exp=00000", {zero, neg, cout, ovf, less}); end
    endtask

    task automatic test_back_to_back;
        logic held_bad;
        logic [15:0] exp;
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        out_ready = 1'b0;
        drive(OP_ADD, 16'h0010, 16'h0020, 1'b0);
        total++; if ({out_valid, in_ready, result} !== {2'b10, 16'h0030}) begin bad++; $display("FAIL bp_first got=%b%b/%h exp=10/0030", out_valid, in_ready, result); end
        in_valid = 1'b1; op = OP_ADD; a = 16'h0100; b = 16'h0200; cin = 1'b0;
        held_bad = 1'b0;
        repeat (3) begin
            @(posedge clk); @(negedge clk);
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || result !== 16'h0030) held_bad = 1'b1;
        end
        total++; if (held_bad !== 1'b0) begin bad++; $display("FAIL bp_hold got=%b exp=0", held_bad); end
        out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
        @(posedge clk); @(negedge clk);
        total++; if ({out_valid, result} !== {1'b1, 16'h0300}) begin bad++; $display("FAIL bp_second got=%b/%h exp=1/0300", out_valid, result); end
        for (int i = 1; i <= 3; i++) begin
            a = 16'(i * 16'h0011); b = 16'h0001; exp = 16'(i * 16'h0011 + 1);
            @(posedge clk); @(negedge clk);
            total++; if ({out_valid, result} !== {1'b1, exp}) begin bad++; $display("FAIL b2b_%0d got=%b/%h exp=1/%h", i, out_valid, result, exp); end
        end
        in_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_reset_mid_mul;
        logic phantom;
        in_valid = 1'b1; op = OP_MUL; a = 16'h0003; b = 16'h0005;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        repeat (4) begin @(posedge clk); @(negedge clk); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rmul_busy_before got=%b exp=1", busy); end
        rst = 1'b1;
        #1;
        total++; if ({out_valid, busy, result} !== {2'b00, 16'h0000}) begin bad++; $display("FAIL rmul_abort got=%b%b/%h exp=00/0000", out_valid, busy, result); end
        @(negedge clk);
        rst = 1'b0;
        drive(OP_ADD, 16'h0005, 16'h0007, 1'b0);
        total++; if ({out_valid, busy, result} !== {2'b10, 16'h000C}) begin bad++; $display("FAIL rmul_add got=%b%b/%h exp=10/000C", out_valid, busy, result); end
        phantom = 1'b0;
        repeat (20) begin
            @(posedge clk); @(negedge clk);
            if (out_valid !== 1'b0 || busy !== 1'b0) phantom = 1'b1;
        end
        total++; if (phantom !== 1'b0) begin bad++; $display("FAIL rmul_phantom got=%b exp=0", phantom); end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; op = OP_AND;
        test_reset;
        test_logic;
        test_add;
        test_sub;
        test_mul;
        test_back_to_back;
        test_reset_mid_mul;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_multicycle.md
# alu_multicycle

Parametrised, registered successor to the 16-bit combinational ALU. Accepts one operation per valid/ready handshake and returns a registered result with Zero/Negative/Carry/Overflow/Less flags. Adds XOR, unsigned compare and an iterative shift-add multiply. It sits between the instruction decoder and the register-file writeback, and absorbs writeback back-pressure.

## Interface
Parameters:
- WIDTH, 16, operand/result width (≥4)
- CNT_W, $clog2(WIDTH), multiply iteration counter width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operation request
- in_ready  out  1  block can accept this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in (ADD only)
- op  in  3  operation select
- out_valid  out  1  result/flags valid
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  registered result
- cout  out  1  carry out (ADD); no-borrow (SUB/SLT/SLTU)
- zero  out  1  result == 0
- neg  out  1  result[WIDTH-1]
- ovf  out  1  signed overflow (ADD/SUB)
- less  out  1  A<B (signed for SUB/SLT, unsigned for SLTU)
- busy  out  1  multiply in progress

## Operation
- Opcodes: 000 AND, 001 OR, 010 XOR, 011 SLTU, 100 ADD (a+b+cin), 101 SUB (a+~b+1), 110 SLT, 111 MUL.
- SLT/SLTU result = {WIDTH-1 zeros, less}.
- Signed less = neg_of_diff XOR ovf_of_diff. Unsigned less = ~cout of a−b.
- ovf and cout are 0 for logic ops. less is 0 for AND/OR/XOR/ADD/MUL.
- MUL returns the low WIDTH bits of a*b. It uses a shift-add over WIDTH iterations, one bit of b per cycle, LSB first. Flags: zero/neg from the result; cout/ovf/less = 0.
- FSM:
  - IDLE → MUL_BUSY on accepted MUL.
  - MUL_BUSY → IDLE once the final product is loaded into the output register.
  - Non-MUL ops stay in IDLE.
- in_ready = (state==IDLE) && (!out_valid || out_ready). Ops are accepted when in_valid && in_ready.
- Output register: loaded on the accept edge for single-cycle ops, or on MUL completion. out_valid clears on out_valid && out_ready when no new load occurs on the same edge.
- Simultaneous drain and load: the new result replaces the old, and out_valid stays 1.
- MUL completion while the old result is still unaccepted: the counter holds at its final value, busy stays 1, and completion retries each cycle.
- Inputs are ignored when in_valid=0 or in_ready=0. Operands are captured at accept, so a/b may change after accept.

## Timing
- Reset (asynchronous): state=IDLE; counter=0; out_valid=0; result=0; all flags=0; busy=0. in_ready=1 one cycle after reset deasserts.
- Single-cycle op accepted at edge N: out_valid=1 and result valid after edge N.
- MUL accepted at edge N: busy=1 after N. out_valid=1 after edge N+WIDTH when unstalled, with busy=0 from the same edge.
- Throughput: one single-cycle op per clock when out_ready=1; one MUL per WIDTH+1 clocks.
- result/flags are stable while out_valid && !out_ready.
- Reset asserted during MUL_BUSY aborts the multiply immediately. No result is produced.

## Structure
- Package alu_pkg: opcode localparams (OP_AND … OP_MUL) and FSM state encoding (ST_IDLE, ST_MUL_BUSY).
- Sub-module alu_mul_seq: the shift-add multiplier with a start/done interface and internal counter. The top level holds the combinational add/logic path, flag generation, output register and handshake.

## Test plan
All scenarios use WIDTH=16.
- AND a=AAAA, b=5555 → result 0000, zero=1, out_valid one cycle after accept.
- ADD a=0001, b=0002, cin=0 → 0003, cout=0, ovf=0. ADD a=FFFF, b=0001 → 0000, cout=1, zero=1.
- SUB a=8000, b=0001 → 7FFF, ovf=1, less=1, cout=1. SUB a=7FFF, b=FFFE → 8001, ovf=1, neg=1, less=0. SLTU a=0001, b=FFFF → 0001.
- MUL a=0003, b=0005 → 000F, out_valid exactly 16 cycles after accept, in_ready=0 and busy=1 meanwhile. MUL FFFF×FFFF → 0001.
- Back-pressure: hold out_ready=0 over two ADDs. Expect the second request stalled (in_ready=0) and result held. Raise out_ready and expect both results in order with no loss.
- Assert rst 5 cycles into a MUL. Expect out_valid=0, busy=0 and result=0 immediately, and a fresh ADD after reset to complete normally.
